// File: rtl/mac_loop_sequencer_if.sv
// Bus bundle between the MAC loop sequencer and its surroundings.
//   master : job requester / datapath side (drives job fields and stall,
//            receives DataMem read and MAC strobes)
//   slave  : the sequencer itself
// Signals:
//   start, n_taps, x_head, x_base, h_base : job request and its operands
//   stall                                 : DataMem port busy, blocks read issue
//   dmem_addr, dmem_rd                    : DataMem read request
//   acc_clear, t_load, p_load, acc_add    : T / P / Accumulator strobes
//   busy, done                            : job status
interface mac_loop_sequencer_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned TAP_W  = 7
);
    logic              start;
    logic [TAP_W-1:0]  n_taps;
    logic [ADDR_W-1:0] x_head;
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] h_base;
    logic              stall;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_rd;
    logic              acc_clear;
    logic              t_load;
    logic              p_load;
    logic              acc_add;
    logic              busy;
    logic              done;

    modport master (
        output start, n_taps, x_head, x_base, h_base, stall,
        input  dmem_addr, dmem_rd, acc_clear, t_load, p_load, acc_add, busy, done
    );

    modport slave (
        input  start, n_taps, x_head, x_base, h_base, stall,
        output dmem_addr, dmem_rd, acc_clear, t_load, p_load, acc_add, busy, done
    );
endinterface

// File: rtl/mac_loop_sequencer.sv
// Sequences the T / P / Accumulator MAC datapath through an N-tap FIR dot
// product. Per tap it reads the sample (newest first, circular buffer) and
// then the coefficient, strobing T-load, P-load and accumulate in turn.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : slave side of mac_loop_sequencer_if (job request, stall,
//           DataMem read request, MAC strobes, busy/done)
module mac_loop_sequencer #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TAP_W   = 7,
    parameter int unsigned BUF_LEN = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    mac_loop_sequencer_if.slave     bus
);

    // Counter must hold both any requested tap count and the clamp value.
    localparam int unsigned BUF_W = $clog2(BUF_LEN + 1);
    localparam int unsigned CNT_W = (TAP_W > BUF_W) ? TAP_W : BUF_W;

    typedef enum logic [2:0] {
        StIdle, StClr, StRx, StLt, StRh, StMp, StAc, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  n_eff_q, n_eff_d;
    logic [ADDR_W-1:0] x_head_q, x_head_d;
    logic [ADDR_W-1:0] x_base_q, x_base_d;
    logic [ADDR_W-1:0] h_base_q, h_base_d;

    logic [CNT_W-1:0]  n_req;
    logic [CNT_W-1:0]  k_inc;
    logic [ADDR_W-1:0] k_addr;
    logic [ADDR_W-1:0] idx;

    assign n_req  = CNT_W'(bus.n_taps);
    assign k_inc  = k_q + CNT_W'(1);
    assign k_addr = ADDR_W'(k_q);

    // Newest-first walk back through the circular buffer, wrapping below 0.
    assign idx = (x_head_q >= k_addr) ? (x_head_q - k_addr)
                                      : (x_head_q + ADDR_W'(BUF_LEN) - k_addr);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            n_eff_q  <= '0;
            x_head_q <= '0;
            x_base_q <= '0;
            h_base_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_eff_q  <= n_eff_d;
            x_head_q <= x_head_d;
            x_base_q <= x_base_d;
            h_base_q <= h_base_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_eff_d  = n_eff_q;
        x_head_d = x_head_q;
        x_base_d = x_base_q;
        h_base_d = h_base_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    n_eff_d  = (n_req > CNT_W'(BUF_LEN)) ? CNT_W'(BUF_LEN) : n_req;
                    x_head_d = bus.x_head;
                    x_base_d = bus.x_base;
                    h_base_d = bus.h_base;
                    k_d      = '0;
                    state_d  = StClr;
                end
            end
            StClr:  state_d = (n_eff_q == '0) ? StDone : StRx;
            StRx:   if (!bus.stall) state_d = StLt;
            StLt:   state_d = StRh;
            StRh:   if (!bus.stall) state_d = StMp;
            StMp:   state_d = StAc;
            StAc: begin
                k_d     = k_inc;
                state_d = (k_inc == n_eff_q) ? StDone : StRx;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode. The address is held through a stall; only the strobe drops.
    always_comb begin
        bus.dmem_addr = '0;
        bus.dmem_rd   = 1'b0;
        bus.acc_clear = 1'b0;
        bus.t_load    = 1'b0;
        bus.p_load    = 1'b0;
        bus.acc_add   = 1'b0;
        bus.busy      = (state_q != StIdle);
        bus.done      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StClr:  bus.acc_clear = 1'b1;
            StRx: begin
                bus.dmem_addr = x_base_q + idx;
                bus.dmem_rd   = ~bus.stall;
            end
            StLt:   bus.t_load = 1'b1;
            StRh: begin
                bus.dmem_addr = h_base_q + k_addr;
                bus.dmem_rd   = ~bus.stall;
            end
            StMp:   bus.p_load  = 1'b1;
            StAc:   bus.acc_add = 1'b1;
            StDone: bus.done    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mac_loop_sequencer.sv
module tb_mac_loop_sequencer;

    localparam int ADDR_W  = 10;
    localparam int TAP_W   = 7;
    localparam int BUF_LEN = 64;
    localparam int MEM_SZ  = 1 << ADDR_W;

    logic clk;
    logic reset;

    mac_loop_sequencer_if #(.ADDR_W(ADDR_W), .TAP_W(TAP_W)) ifc ();

    mac_loop_sequencer #(
        .ADDR_W (ADDR_W),
        .TAP_W  (TAP_W),
        .BUF_LEN(BUF_LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // DataMem contents and the T / P / Accumulator datapath the strobes drive.
    logic [15:0] mem [MEM_SZ];
    longint      q_reg, t_reg, p_reg, acc;

    typedef struct {
        int n; int xh; int xb; int hb;
        int sc; int sl; int rc;
        int exp_done; int exp_adds; int exp_last_x;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int xaddr(input int xh, input int xb, input int j);
        int idx;
        idx = (xh >= j) ? xh - j : xh + BUF_LEN - j;
        return (xb + idx) % MEM_SZ;
    endfunction

    function automatic longint pack_outs();
        return {ifc.busy, ifc.done, ifc.acc_clear, ifc.dmem_rd, ifc.t_load,
                ifc.p_load, ifc.acc_add, ifc.dmem_addr};
    endfunction

    // Runs one job. The reference is an ideal schedule position: slot 0 clears,
    // each tap then takes five slots (sample read, T, coeff read, P, accumulate),
    // and the slot after the last tap is done. A stalled read slot does not advance.
    task automatic run_job(input int n, input int xh, input int xb, input int hb,
                           input int sc, input int sl, input int rc, input bit rs,
                           output int done_cyc, output int adds, output int last_x);
        int     n_eff, pos, done_pos, j, ph;
        bit     st, finished, rd_slot;
        logic   e_rd, e_t, e_p, e_acc;
        int     e_addr;
        longint exp_acc, exp_t, exp_p, exp_vec;

        n_eff = (n > BUF_LEN) ? BUF_LEN : n;
        exp_acc = 0;
        for (int k = 0; k < n_eff; k++)
            exp_acc += longint'(mem[xaddr(xh, xb, k)]) * longint'(mem[(hb + k) % MEM_SZ]);

        ifc.n_taps = TAP_W'(n);
        ifc.x_head = ADDR_W'(xh);
        ifc.x_base = ADDR_W'(xb);
        ifc.h_base = ADDR_W'(hb);
        ifc.start  = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;

        pos = 0; done_pos = 1 + 5 * n_eff;
        done_cyc = -1; adds = 0; last_x = -1; finished = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (cyc == 1) begin
                // Job operands must already be latched.
                ifc.n_taps = TAP_W'($urandom);
                ifc.x_head = ADDR_W'($urandom);
                ifc.x_base = ADDR_W'($urandom);
                ifc.h_base = ADDR_W'($urandom);
            end
            st = (cyc >= sc && cyc < sc + sl) || (rs && $urandom_range(2) == 0);
            ifc.stall = st;
            ifc.start = (cyc == rc);
            @(negedge clk);

            e_rd = 1'b0; e_t = 1'b0; e_p = 1'b0; e_acc = 1'b0; e_addr = 0;
            rd_slot = 1'b0; ph = -1;
            if (pos >= 1 && pos < done_pos) begin
                j  = (pos - 1) / 5;
                ph = (pos - 1) % 5;
                rd_slot = (ph == 0 || ph == 2);
                e_rd  = rd_slot && !st;
                e_addr = (ph == 0) ? xaddr(xh, xb, j) : (ph == 2) ? (hb + j) % MEM_SZ : 0;
                e_t   = (ph == 1);
                e_p   = (ph == 3);
                e_acc = (ph == 4);
            end
            exp_vec = {pos <= done_pos, pos == done_pos, pos == 0, e_rd, e_t, e_p, e_acc,
                       ADDR_W'(e_addr)};
            check($sformatf("cyc%0d busy/done/clr/rd/t/p/add/addr", cyc), pack_outs(), exp_vec);

            if (ifc.acc_add) adds++;
            if (ifc.done && done_cyc < 0) done_cyc = cyc;
            if (ifc.dmem_rd && ph == 0) last_x = int'(ifc.dmem_addr);

            if (ifc.acc_clear) acc = 0;
            if (ifc.acc_add)   acc = acc + p_reg;
            if (ifc.p_load)    p_reg = t_reg * q_reg;
            if (ifc.t_load)    t_reg = q_reg;
            if (ifc.dmem_rd)   q_reg = longint'(mem[ifc.dmem_addr]);

            if (!(rd_slot && st)) pos++;
            @(posedge clk);
            #1;
            if (pos == done_pos + 3) begin
                finished = 1'b1;
                break;
            end
        end
        ifc.stall = 1'b0;
        ifc.start = 1'b0;
        if (!finished) check("job_timeout", 1, 0);
        check("accumulator", acc, exp_acc);
        if (n_eff > 0) begin
            exp_t = longint'(mem[xaddr(xh, xb, n_eff - 1)]);
            exp_p = exp_t * longint'(mem[(hb + n_eff - 1) % MEM_SZ]);
            check("t_reg_last_tap", t_reg, exp_t);
            check("p_reg_last_tap", p_reg, exp_p);
        end
    endtask

    int dc, ad, lx, n;

    initial begin
        checks = 0; failures = 0;
        q_reg = 0; t_reg = 0; p_reg = 0; acc = 0;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 16'($urandom);

        //         n    xh  xb    hb    sc sl rc  done adds last_x
        tbl[0] = '{3,   5,  100,  200,  0, 0, 0,  17,  3,   103};
        tbl[1] = '{4,   1,  300,  400,  0, 0, 0,  22,  4,   362};
        tbl[2] = '{0,   7,  10,   20,   0, 0, 0,  2,   0,   -1};
        tbl[3] = '{3,   5,  100,  200,  4, 3, 0,  20,  3,   103};
        tbl[4] = '{100, 10, 500,  600,  0, 0, 50, 322, 64,  511};
        tbl[5] = '{2,   0,  0,    900,  0, 0, 12, 12,  2,   63};
        tbl[6] = '{5,   3,  1020, 1022, 0, 0, 0,  27,  5,   59};

        reset = 1'b0;
        ifc.start = 1'b0; ifc.stall = 1'b0;
        ifc.n_taps = '0; ifc.x_head = '0; ifc.x_base = '0; ifc.h_base = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", pack_outs(), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            run_job(tbl[v].n, tbl[v].xh, tbl[v].xb, tbl[v].hb, tbl[v].sc, tbl[v].sl,
                    tbl[v].rc, 1'b0, dc, ad, lx);
            check($sformatf("vec%0d done_cycle", v), dc, tbl[v].exp_done);
            check($sformatf("vec%0d acc_adds", v), ad, tbl[v].exp_adds);
            if (tbl[v].exp_adds > 0)
                check($sformatf("vec%0d last_sample_addr", v), lx, tbl[v].exp_last_x);
        end

        // Asynchronous reset during MP of tap 1 abandons the job.
        ifc.n_taps = 7'd3; ifc.x_head = 10'd5; ifc.x_base = 10'd100; ifc.h_base = 10'd200;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midjob_p_load_before_reset", ifc.p_load, 1);
        reset = 1'b0;
        #1;
        check("midjob_reset_outputs", pack_outs(), 0);
        repeat (2) begin
            @(negedge clk);
            check("reset_held_no_done_busy", {ifc.done, ifc.busy}, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_job(3, 5, 100, 200, 0, 0, 0, 1'b0, dc, ad, lx);
        check("after_reset done_cycle", dc, 17);
        check("after_reset acc_adds", ad, 3);

        // Randomized jobs with random stalls.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 80);
            run_job(n, $urandom_range(0, BUF_LEN - 1), $urandom_range(0, MEM_SZ - 1),
                    $urandom_range(0, MEM_SZ - 1), 0, 0, 0, 1'b1, dc, ad, lx);
            check($sformatf("rand%0d acc_adds", r), ad, (n > BUF_LEN) ? BUF_LEN : n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
